axis_fifo_rd_gate: RTL

Parametrised read-side gate for an asynchronous AXI-Stream FIFO feeding the GTH transmit path. It holds the FIFO read side closed until a programmable occupancy threshold is reached, then streams a complete frame continuously up to and including TLAST. An optional back-to-back mode keeps streaming across frame boundaries while occupancy allows, and the block reports underruns. It sits in the GT TX user-clock domain, between the FIFO master port and the GT datapath.

---
 rtl/axis_fifo_rd_gate_pkg.sv | 18 +
 rtl/axis_fifo_rd_gate_sat_counter.sv | 23 ++
 rtl/axis_fifo_rd_gate.sv | 118 +++++++++++
 3 files changed

// File: rtl/axis_fifo_rd_gate_pkg.sv
// Shared types and constants for the AXI-Stream FIFO read-side gate.
package axis_fifo_rd_gate_pkg;

    // Gate FSM encodings; the numeric values are visible on the state port.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        STREAM = 2'd2
    } state_t;

    // Default occupancy (beats) required before a frame may start.
    localparam int THRESHOLD_DEFAULT = 512;

    // RUN_MODE selections.
    localparam int MODE_PER_FRAME = 0;
    localparam int MODE_B2B       = 1;

endpackage

// File: rtl/axis_fifo_rd_gate_sat_counter.sv
// Statistics counter: increments by one, synchronous clear, and either
// wraps or sticks at all-ones depending on SATURATE.
module sat_counter #(
    parameter int W        = 16,
    parameter bit SATURATE = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count register; saturation suppresses the increment at all-ones.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && !(SATURATE && (&count))) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/axis_fifo_rd_gate.sv
// Read-side gate for an asynchronous AXI-Stream FIFO in the GT TX user-clock
// domain. Holds reads off until occupancy reaches THRESHOLD, then streams a
// whole frame through TLAST; RUN_MODE=1 chains frames while occupancy allows.
// Optional statistics counters are built when AXIS_FIFO_RD_GATE_STATS_EN is
// defined; otherwise frame_count and underrun_count read as zero.
module axis_fifo_rd_gate
    import axis_fifo_rd_gate_pkg::*;
#(
    parameter int COUNT_W   = 12,
    parameter int THRESHOLD = THRESHOLD_DEFAULT,
    parameter int RUN_MODE  = MODE_PER_FRAME,
    parameter int STAT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               GT_Tx_active,
    input  logic [COUNT_W-1:0] fifo_rd_data_count,
    input  logic               fifo_out_TVALID,
    input  logic               fifo_out_TLAST,
    input  logic               gt_tx_ready,
    output logic               fifo_out_TREADY,
    output logic               fifo_rd_enable,
    output logic               underrun,
    input  logic               underrun_clr,
    output logic [1:0]         state,
    output logic [STAT_W-1:0]  frame_count,
    output logic [STAT_W-1:0]  underrun_count
);

    localparam logic [COUNT_W-1:0] THRESH = COUNT_W'(THRESHOLD);

    state_t state_q;
    state_t state_d;
    logic   rd_en_d;
    logic   thresh_met;
    logic   tlast_beat;
    logic   underrun_set;

    // The count may lag real occupancy; THRESHOLD is expected to absorb that.
    assign thresh_met      = (fifo_rd_data_count >= THRESH);
    assign fifo_out_TREADY = fifo_rd_enable & gt_tx_ready;
    assign tlast_beat      = fifo_out_TVALID & fifo_out_TREADY & fifo_out_TLAST;
    assign underrun_set    = (state_q == STREAM) & gt_tx_ready & ~fifo_out_TVALID;
    assign state           = state_q;

    // State and read-window registers; reset closes the window on the next edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            fifo_rd_enable <= 1'b0;
        end else begin
            state_q        <= state_d;
            fifo_rd_enable <= rd_en_d;
        end
    end

    // Next-state logic; a frame in progress is only left on its TLAST beat.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (GT_Tx_active) state_d = FILL;
            end
            FILL: begin
                if (!GT_Tx_active)   state_d = IDLE;
                else if (thresh_met) state_d = STREAM;
            end
            STREAM: begin
                if (tlast_beat) begin
                    if (!GT_Tx_active)                           state_d = IDLE;
                    else if ((RUN_MODE == MODE_B2B) && thresh_met) state_d = STREAM;
                    else                                         state_d = FILL;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Read window follows the next state so it drops right after TLAST.
    always_comb begin
        rd_en_d = (state_d == STREAM);
    end

    // Sticky underrun flag; a new gap takes priority over a clear.
    always_ff @(posedge clk) begin
        if (rst)               underrun <= 1'b0;
        else if (underrun_set) underrun <= 1'b1;
        else if (underrun_clr) underrun <= 1'b0;
    end

`ifdef AXIS_FIFO_RD_GATE_STATS_EN
    sat_counter #(
        .W        (STAT_W),
        .SATURATE (1'b0)
    ) u_frame_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .inc   (tlast_beat),
        .count (frame_count)
    );

    sat_counter #(
        .W        (STAT_W),
        .SATURATE (1'b1)
    ) u_underrun_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .inc   (underrun_set),
        .count (underrun_count)
    );
`else
    assign frame_count    = '0;
    assign underrun_count = '0;
`endif

endmodule
